load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; only 32 supported.
REQ-003 SHALL have port Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port Req_Valid  input  1  core issues an access.
REQ-006 SHALL have port Req_Ready  output  1  unit can accept an access.
REQ-007 SHALL have port Req_Write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port Req_Funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port Req_Address  input  ADDR_W  byte address.
REQ-010 SHALL have port Req_Store_Data  input  32  store data, right-aligned.
REQ-011 SHALL have port Resp_Valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port Resp_Load_Data  output  32  extended load result.
REQ-013 SHALL have port Resp_Error  output  1  misaligned or illegal access, qualified by Resp_Valid.
REQ-014 SHALL have port Mem_Address  output  ADDR_W  word-aligned byte address to data RAM.
REQ-015 SHALL have port Mem_Write_Data  output  32  full word to RAM.
REQ-016 SHALL have port Mem_Write_Enable  output  1  RAM write strobe, sampled on Clk.
REQ-017 SHALL have port Mem_Read_Data  input  32  RAM combinational read of Mem_Address.

Function
REQ-018 SHALL use states IDLE, READ, WRITE, RESP; Req_Ready = 1 only in IDLE with Rst_n high.
REQ-019 SHALL accept a request when Req_Valid and Req_Ready are high at a clock edge, latching Write, Funct3, Address and Store_Data.
REQ-020 SHALL flag error if Funct3 is not in {000,001,010,100,101} for loads or not in {000,001,010} for stores, if H/HU has Address[0]=1, or if W has Address[1:0]!=00.
REQ-021 SHALL, on an error, go IDLE->RESP with no memory access and Resp_Error=1 and Resp_Load_Data=0.
REQ-022 SHALL handle a load as IDLE->READ->RESP: in READ it captures Mem_Read_Data and extracts and extends it into the result register; Resp_Valid is high 2 cycles after acceptance.
REQ-023 SHALL handle SW as IDLE->WRITE->RESP, with Mem_Write_Data = Store_Data in WRITE.
REQ-024 SHALL handle SB/SH as IDLE->READ->WRITE->RESP (read-modify-write): only the addressed lane is replaced in the captured word and the others are preserved; Resp_Valid is high 3 cycles after acceptance.
REQ-025 SHALL use little-endian lanes: byte k = bits [8k+7:8k], with k = Address[1:0]; the halfword is at lane Address[1]*2.
REQ-026 SHALL make B/H sign-extend and BU/HU zero-extend.
REQ-027 SHALL drive Mem_Address = {latched Address[ADDR_W-1:2], 2'b00} in READ and WRITE, and hold its last value otherwise.
REQ-028 SHALL assert Mem_Write_Enable only in WRITE with Rst_n high, for exactly one cycle per store.
REQ-029 SHALL assert Resp_Valid for exactly one cycle in RESP, then return to IDLE; Resp_Load_Data and Resp_Error hold until the next response; there is no response backpressure.
REQ-030 SHALL treat a store response as Resp_Load_Data = 0.
REQ-031 SHALL ignore Req_Valid while not in IDLE; the next acceptance is earliest the cycle after RESP.

Reset
REQ-032 SHALL, while Rst_n is low at an edge, force IDLE and clear Resp_Valid, Resp_Error, Resp_Load_Data, Mem_Address and Mem_Write_Data to 0.
REQ-033 SHALL combinationally gate Mem_Write_Enable to 0 while Rst_n is low, so reset mid-RMW causes no partial write and the in-flight access is dropped without a response.

Structure
REQ-034 SHALL place the Funct3 width constants and the state enumeration in shared package lsu_pkg.
REQ-035 SHALL put lane extraction/extension and store merging in combinational sub-module lsu_align; the FSM and registers live in load_store_unit.

Verification
REQ-036 SHALL show: RAM word 0x8 = 0x11223344; LB at 0xB -> Resp_Load_Data = 0x00000011; LH at 0xA -> 0x00001122; both with Resp_Valid 2 cycles after acceptance.
REQ-037 SHALL show: RAM word 0x4 = 0x000080F0; LB at 0x4 -> 0xFFFFFFF0; LBU at 0x4 -> 0x000000F0; LH at 0x4 -> 0xFFFF80F0.
REQ-038 SHALL show: RAM word 0x10 = 0xAABBCCDD; SB 0x55 at 0x11 -> RAM = 0xAABB55DD after exactly one write pulse, with Resp_Valid 3 cycles after acceptance.
REQ-039 SHALL show: SW 0xDEADBEEF at 0x20 -> RAM word 0x20 = 0xDEADBEEF; LW at 0x20 then returns 0xDEADBEEF.
REQ-040 SHALL show: LW at 0x22, SH at 0x13 and Funct3 = 011 -> Resp_Error = 1 one cycle after acceptance, with no Mem_Write_Enable pulse.
REQ-041 SHALL show: Rst_n low during READ of an SB -> no write, RAM unchanged, no Resp_Valid, Req_Ready = 1 in the first cycle after Rst_n returns high.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the access legality rule.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Illegal width code for the direction, or a halfword/word that is not naturally aligned.
    function automatic logic access_error(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic err;
        err = 1'b1;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = offset[0];
            F3_W:    err = (offset != 2'b00);
            F3_BU:   err = write;
            F3_HU:   err = write | offset[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Byte and halfword stores must read the word first to preserve the other lanes.
    function automatic logic needs_rmw(input logic write, input logic [2:0] funct3);
        return write && (funct3 != F3_W);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, and lane merging for
// partial stores; purely combinational, little-endian lanes.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] read_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = read_word[7:0];
        case (offset)
            2'd0: lane_byte = read_word[7:0];
            2'd1: lane_byte = read_word[15:8];
            2'd2: lane_byte = read_word[23:16];
            2'd3: lane_byte = read_word[31:24];
            default: lane_byte = read_word[7:0];
        endcase
        lane_half = offset[1] ? read_word[31:16] : read_word[15:0];
    end

    always_comb begin
        load_data = 32'h0;
        case (funct3)
            F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_data = {24'h0, lane_byte};
            F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_data = {16'h0, lane_half};
            F3_W:    load_data = read_word;
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        merged_word = read_word;
        case (funct3)
            F3_B:    merged_word[{offset, 3'b000} +: 8]     = store_data[7:0];
            F3_H:    merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
            F3_W:    merged_word = store_data;
            default: merged_word = read_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the core and a combinational-read
// data RAM; partial stores are done as read-modify-write of the whole word.
//
// state | meaning
// IDLE  | ready for a request
// READ  | word on Mem_Read_Data is captured (load result or RMW base)
// WRITE | Mem_Write_Enable high for one cycle
// RESP  | Resp_Valid pulse, then back to IDLE
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Req_Write,
    input  logic [2:0]        Req_Funct3,
    input  logic [ADDR_W-1:0] Req_Address,
    input  logic [DATA_W-1:0] Req_Store_Data,
    output logic              Resp_Valid,
    output logic [DATA_W-1:0] Resp_Load_Data,
    output logic              Resp_Error,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_Write_Data,
    output logic              Mem_Write_Enable,
    input  logic [DATA_W-1:0] Mem_Read_Data
);

    lsu_state_t        state;
    logic              lat_write;
    logic [2:0]        lat_funct3;
    logic [1:0]        lat_offset;
    logic [DATA_W-1:0] lat_store_data;
    logic [31:0]       align_load_data;
    logic [31:0]       align_merged_word;

    lsu_align u_align (
        .funct3      (lat_funct3),
        .offset      (lat_offset),
        .read_word   (Mem_Read_Data),
        .store_data  (lat_store_data),
        .load_data   (align_load_data),
        .merged_word (align_merged_word)
    );

    // Both are gated by Rst_n so a reset mid-RMW can never leak a partial write.
    assign Req_Ready        = (state == IDLE)  && Rst_n;
    assign Mem_Write_Enable = (state == WRITE) && Rst_n;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state          <= IDLE;
            lat_write      <= 1'b0;
            lat_funct3     <= F3_B;
            lat_offset     <= 2'b00;
            lat_store_data <= '0;
            Resp_Valid     <= 1'b0;
            Resp_Error     <= 1'b0;
            Resp_Load_Data <= '0;
            Mem_Address    <= '0;
            Mem_Write_Data <= '0;
        end else begin
            Resp_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (Req_Valid) begin
                        lat_write      <= Req_Write;
                        lat_funct3     <= Req_Funct3;
                        lat_offset     <= Req_Address[1:0];
                        lat_store_data <= Req_Store_Data;
                        if (access_error(Req_Write, Req_Funct3, Req_Address[1:0])) begin
                            state          <= RESP;
                            Resp_Valid     <= 1'b1;
                            Resp_Error     <= 1'b1;
                            Resp_Load_Data <= '0;
                        end else begin
                            Mem_Address <= {Req_Address[ADDR_W-1:2], 2'b00};
                            if (Req_Write && !needs_rmw(Req_Write, Req_Funct3)) begin
                                Mem_Write_Data <= Req_Store_Data;
                                state          <= WRITE;
                            end else begin
                                state <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    if (lat_write) begin
                        Mem_Write_Data <= align_merged_word;
                        state          <= WRITE;
                    end else begin
                        Resp_Load_Data <= align_load_data;
                        Resp_Error     <= 1'b0;
                        Resp_Valid     <= 1'b1;
                        state          <= RESP;
                    end
                end
                WRITE: begin
                    Resp_Load_Data <= '0;
                    Resp_Error     <= 1'b0;
                    Resp_Valid     <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, busy/reset sequences and
// random accesses checked against a word-array model of memory.
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_Write;
    logic [2:0]  Req_Funct3;
    logic [31:0] Req_Address;
    logic [31:0] Req_Store_Data;
    logic        Resp_Valid;
    logic [31:0] Resp_Load_Data;
    logic        Resp_Error;
    logic [31:0] Mem_Address;
    logic [31:0] Mem_Write_Data;
    logic        Mem_Write_Enable;
    logic [31:0] Mem_Read_Data;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .Clk              (Clk),
        .Rst_n            (Rst_n),
        .Req_Valid        (Req_Valid),
        .Req_Ready        (Req_Ready),
        .Req_Write        (Req_Write),
        .Req_Funct3       (Req_Funct3),
        .Req_Address      (Req_Address),
        .Req_Store_Data   (Req_Store_Data),
        .Resp_Valid       (Resp_Valid),
        .Resp_Load_Data   (Resp_Load_Data),
        .Resp_Error       (Resp_Error),
        .Mem_Address      (Mem_Address),
        .Mem_Write_Data   (Mem_Write_Data),
        .Mem_Write_Enable (Mem_Write_Enable),
        .Mem_Read_Data    (Mem_Read_Data)
    );

    always #5 Clk = ~Clk;

    logic [31:0] ram [0:255];
    logic [31:0] model_ram [0:255];
    int          wr_count = 0;
    logic [31:0] last_wr_addr = 32'h0;

    assign Mem_Read_Data = ram[Mem_Address[9:2]];

    always @(posedge Clk) begin
        if (Mem_Write_Enable) begin
            ram[Mem_Address[9:2]] <= Mem_Write_Data;
            wr_count     <= wr_count + 1;
            last_wr_addr <= Mem_Address;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: memory as a plain word array, lanes by shift and mask.
    function automatic void model_op(input logic wr, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] sd,
                                     output logic [31:0] d, output logic e, output int lat);
        int unsigned off;
        int unsigned size;
        logic [31:0] w;
        logic [31:0] mask;
        off  = addr % 4;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (wr) e = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    e = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!e && (off % size) != 0) e = 1'b1;
        d = 32'h0;
        if (e) begin
            lat = 1;
            return;
        end
        w = model_ram[(addr / 4) % 256];
        if (size == 4) mask = 32'hFFFF_FFFF;
        else           mask = ((32'h1 << (8 * size)) - 1) << (8 * off);
        if (wr) begin
            model_ram[(addr / 4) % 256] = (w & ~mask) | ((sd << (8 * off)) & mask);
            lat = (size == 4) ? 2 : 3;
        end else begin
            d = (w & mask) >> (8 * off);
            if (f3 == 3'd0 && d >= 32'h80)   d = d | 32'hFFFF_FF00;
            if (f3 == 3'd1 && d >= 32'h8000) d = d | 32'hFFFF_0000;
            lat = 2;
        end
    endfunction

    // Issue one request; lat counts clock edges from the accepting edge to the first sample with Resp_Valid.
    task automatic do_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] sd, output logic [31:0] d, output logic e,
                             output int lat);
        @(negedge Clk);
        Req_Valid      = 1'b1;
        Req_Write      = wr;
        Req_Funct3     = f3;
        Req_Address    = addr;
        Req_Store_Data = sd;
        check("req_ready_idle", {31'h0, Req_Ready}, 32'h1);
        @(posedge Clk);
        #1;
        Req_Valid = 1'b0;
        lat = 0;
        while (lat < 8) begin
            lat++;
            if (Resp_Valid) break;
            @(posedge Clk);
            #1;
        end
        if (!Resp_Valid) lat = -1;
        d = Resp_Load_Data;
        e = Resp_Error;
        @(posedge Clk);
        #1;
        check("resp_valid_one_cycle", {31'h0, Resp_Valid}, 32'h0);
        check("ready_after_resp", {31'h0, Req_Ready}, 32'h1);
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [17];

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        logic [31:0] md;
        logic        me;
        int          mlat;
        int          wbase;
        logic        seen_valid;
        logic        rw;
        logic [2:0]  rf3;
        logic [31:0] raddr;
        logic [31:0] rsd;

        Rst_n = 1'b0;
        Req_Valid = 1'b0;
        Req_Write = 1'b0;
        Req_Funct3 = 3'd0;
        Req_Address = 32'h0;
        Req_Store_Data = 32'h0;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[1] = 32'h0000_80F0;
        ram[2] = 32'h1122_3344;
        ram[4] = 32'hAABB_CCDD;
        for (int i = 16; i < 32; i++) ram[i] = $urandom;
        for (int i = 0; i < 256; i++) model_ram[i] = ram[i];

        vecs[0]  = '{1'b0, 3'b000, 32'h0B, 32'h0,         32'h0000_0011, 1'b0, 2};
        vecs[1]  = '{1'b0, 3'b001, 32'h0A, 32'h0,         32'h0000_1122, 1'b0, 2};
        vecs[2]  = '{1'b0, 3'b000, 32'h04, 32'h0,         32'hFFFF_FFF0, 1'b0, 2};
        vecs[3]  = '{1'b0, 3'b100, 32'h04, 32'h0,         32'h0000_00F0, 1'b0, 2};
        vecs[4]  = '{1'b0, 3'b001, 32'h04, 32'h0,         32'hFFFF_80F0, 1'b0, 2};
        vecs[5]  = '{1'b0, 3'b101, 32'h04, 32'h0,         32'h0000_80F0, 1'b0, 2};
        vecs[6]  = '{1'b1, 3'b000, 32'h11, 32'hFFFF_FF55, 32'h0,         1'b0, 3};
        vecs[7]  = '{1'b0, 3'b010, 32'h10, 32'h0,         32'hAABB_55DD, 1'b0, 2};
        vecs[8]  = '{1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0,         1'b0, 2};
        vecs[9]  = '{1'b0, 3'b010, 32'h20, 32'h0,         32'hDEAD_BEEF, 1'b0, 2};
        vecs[10] = '{1'b0, 3'b010, 32'h22, 32'h0,         32'h0,         1'b1, 1};
        vecs[11] = '{1'b1, 3'b001, 32'h13, 32'h1234_5678, 32'h0,         1'b1, 1};
        vecs[12] = '{1'b0, 3'b011, 32'h00, 32'h0,         32'h0,         1'b1, 1};
        vecs[13] = '{1'b1, 3'b100, 32'h08, 32'h0000_0099, 32'h0,         1'b1, 1};
        vecs[14] = '{1'b1, 3'b001, 32'h06, 32'h0000_CAFE, 32'h0,         1'b0, 3};
        vecs[15] = '{1'b0, 3'b001, 32'h06, 32'h0,         32'hFFFF_CAFE, 1'b0, 2};
        vecs[16] = '{1'b0, 3'b010, 32'h04, 32'h0,         32'hCAFE_80F0, 1'b0, 2};

        repeat (3) @(posedge Clk);
        #1;
        check("rst_resp_valid", {31'h0, Resp_Valid}, 32'h0);
        check("rst_resp_error", {31'h0, Resp_Error}, 32'h0);
        check("rst_load_data", Resp_Load_Data, 32'h0);
        check("rst_mem_address", Mem_Address, 32'h0);
        check("rst_mem_wdata", Mem_Write_Data, 32'h0);
        check("rst_ready_low", {31'h0, Req_Ready}, 32'h0);
        check("rst_wen", {31'h0, Mem_Write_Enable}, 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("ready_after_reset", {31'h0, Req_Ready}, 32'h1);

        foreach (vecs[i]) begin
            wbase = wr_count;
            do_access(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].sd, d, e, lat);
            model_op(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].sd, md, me, mlat);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            check($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, vecs[i].exp_err});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_writes", i), wr_count - wbase,
                  (vecs[i].wr && !vecs[i].exp_err) ? 1 : 0);
            if (vecs[i].wr && !vecs[i].exp_err)
                check($sformatf("vec%0d_wr_addr", i), last_wr_addr, {vecs[i].addr[31:2], 2'b00});
        end
        check("ram_sb", ram[4], 32'hAABB_55DD);
        check("ram_sw", ram[8], 32'hDEAD_BEEF);
        check("ram_sh", ram[1], 32'hCAFE_80F0);

        // Req_Valid held high with different fields while busy must be ignored.
        @(negedge Clk);
        Req_Valid = 1'b1; Req_Write = 1'b0; Req_Funct3 = 3'b010; Req_Address = 32'h04;
        @(posedge Clk);
        #1;
        wbase = wr_count;
        Req_Write = 1'b1; Req_Address = 32'h30; Req_Store_Data = 32'h1234_5678;
        check("busy_ready_low", {31'h0, Req_Ready}, 32'h0);
        @(posedge Clk);
        #1;
        check("busy_resp_valid", {31'h0, Resp_Valid}, 32'h1);
        check("busy_load_data", Resp_Load_Data, 32'hCAFE_80F0);
        Req_Valid = 1'b0;
        @(posedge Clk);
        #1;
        check("busy_no_write", wr_count - wbase, 0);
        check("busy_ram_untouched", ram[12], 32'h0);

        // Reset during the READ phase of an SB drops the access silently.
        @(negedge Clk);
        Req_Valid = 1'b1; Req_Write = 1'b1; Req_Funct3 = 3'b000;
        Req_Address = 32'h12; Req_Store_Data = 32'h77;
        @(posedge Clk);
        #1;
        wbase = wr_count;
        Req_Valid = 1'b0;
        Rst_n = 1'b0;
        check("rst_mid_wen_gated", {31'h0, Mem_Write_Enable}, 32'h0);
        seen_valid = 1'b0;
        @(posedge Clk);
        #1;
        seen_valid |= Resp_Valid;
        check("rst_mid_ready_low", {31'h0, Req_Ready}, 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("rst_mid_ready_after", {31'h0, Req_Ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1;
            seen_valid |= Resp_Valid;
        end
        check("rst_mid_no_resp", {31'h0, seen_valid}, 32'h0);
        check("rst_mid_no_write", wr_count - wbase, 0);
        check("rst_mid_ram", ram[4], 32'hAABB_55DD);
        check("rst_mid_load_data", Resp_Load_Data, 32'h0);

        for (int n = 0; n < 200; n++) begin
            rw    = $urandom_range(0, 1);
            rf3   = $urandom_range(0, 7);
            raddr = 32'h40 + $urandom_range(0, 63);
            rsd   = $urandom;
            wbase = wr_count;
            do_access(rw, rf3, raddr, rsd, d, e, lat);
            model_op(rw, rf3, raddr, rsd, md, me, mlat);
            check($sformatf("rnd%0d_data", n), d, md);
            check($sformatf("rnd%0d_err", n), {31'h0, e}, {31'h0, me});
            check($sformatf("rnd%0d_latency", n), lat, mlat);
            check($sformatf("rnd%0d_writes", n), wr_count - wbase, (rw && !me) ? 1 : 0);
        end
        for (int i = 16; i < 32; i++)
            check($sformatf("rnd_ram_word%0d", i), ram[i], model_ram[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
